// File: rtl/top_module_imp_pkg.sv
// Shared definitions for the 3x3 window scanner.
// Holds the default image geometry, the pixel type and the built-in
// image pattern used when no initialisation file is given.
package top_module_imp_pkg;

  localparam int IMG_W_DEF = 16;
  localparam int IMG_H_DEF = 16;
  localparam int PIX_W     = 8;
  localparam int NB_CNT    = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Built-in pattern addressed linearly: pixel = address mod 256.
  function automatic pixel_t pattern_at(input int unsigned addr);
    return pixel_t'(addr % 32'd256);
  endfunction

  // Built-in pattern addressed by (row, column) for an image of width w.
  function automatic pixel_t pattern_pix(input int unsigned r,
                                         input int unsigned c,
                                         input int unsigned w);
    return pattern_at(r * w + c);
  endfunction

endpackage

// File: rtl/top_module_imp_if.sv
// Window bus between the scan logic and the image ROM.
//   ctr_addr : linear address of the current centre pixel (scanner -> ROM)
//   nb       : the 8 neighbours, nb[0] = (r-1,c-1) ... nb[7] = (r+1,c+1)
// master = scanner side, slave = ROM side.
interface top_module_imp_if
  import top_module_imp_pkg::*;
#(
  parameter int AW = 8
);
  logic [AW-1:0]            ctr_addr;
  pixel_t [NB_CNT-1:0]      nb;

  modport master (output ctr_addr, input  nb);
  modport slave  (input  ctr_addr, output nb);
endinterface

// File: rtl/top_module_imp_image_rom.sv
// Image ROM with a single wide asynchronous read port returning the 8
// neighbours of a centre address.
//   rom_bus.ctr_addr : centre pixel linear address (r*IMG_W + c)
//   rom_bus.nb       : neighbour pixels in out1..out8 order
// The ROM contents are the built-in pattern, a pure function of the address.
module image_rom
  import top_module_imp_pkg::*;
#(
  parameter int    IMG_W     = IMG_W_DEF,
  parameter int    IMG_H     = IMG_H_DEF,
  parameter string INIT_FILE = ""
) (
  top_module_imp_if.slave rom_bus
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int AW    = $clog2(DEPTH);

  logic [AW-1:0] w_base;
  logic [AW-1:0] w_nb_addr [NB_CNT];

  // Neighbour addresses relative to the top-left corner of the window.
  // Unsigned and unclamped: centres never sit on the border.
  always_comb begin
    int k;
    k      = 0;
    w_base = rom_bus.ctr_addr - AW'(IMG_W + 1);
    for (int j = 0; j < NB_CNT; j++) begin
      // Skip window position 4, which is the centre itself.
      if (j < 4) begin
        k = j;
      end else begin
        k = j + 1;
      end
      w_nb_addr[j] = w_base + AW'((k / 3) * IMG_W + (k % 3));
    end
  end

  // Built-in pattern is a pure function of the address, no storage needed.
  always_comb begin
    rom_bus.nb = '0;
    for (int j = 0; j < NB_CNT; j++) begin
      rom_bus.nb[j] = pattern_at(32'(w_nb_addr[j]));
    end
  end

endmodule

// File: rtl/top_module_imp.sv
// 3x3 sliding-window scanner over an internal greyscale image.
// Every clock the 8 neighbours of the current centre pixel are registered
// onto out1..out8, then the centre advances in raster order over the
// interior of the image and wraps at the end of the frame.
//   CLK       : system clock, rising edge
//   RST       : synchronous active-high reset
//   out1..out8: neighbours (r-1,c-1) (r-1,c) (r-1,c+1) (r,c-1)
//               (r,c+1) (r+1,c-1) (r+1,c) (r+1,c+1)
module top_module_imp
  import top_module_imp_pkg::*;
#(
  parameter int    IMG_W     = IMG_W_DEF,
  parameter int    IMG_H     = IMG_H_DEF,
  parameter string INIT_FILE = ""
) (
  input  logic   CLK,
  input  logic   RST,
  output pixel_t out1,
  output pixel_t out2,
  output pixel_t out3,
  output pixel_t out4,
  output pixel_t out5,
  output pixel_t out6,
  output pixel_t out7,
  output pixel_t out8
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int AW = $clog2(IMG_W * IMG_H);

  localparam logic [RW-1:0] ROW_FIRST = RW'(1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 2);
  localparam logic [CW-1:0] COL_FIRST = CW'(1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 2);

  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       w_row_nxt;
  logic [CW-1:0]       w_col_nxt;
  logic [AW-1:0]       w_ctr_addr;
  pixel_t [NB_CNT-1:0] r_win;

  top_module_imp_if #(.AW(AW)) u_bus ();

  image_rom #(
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .rom_bus (u_bus.slave)
  );

  assign w_ctr_addr     = AW'(r_row) * AW'(IMG_W) + AW'(r_col);
  assign u_bus.ctr_addr = w_ctr_addr;

  // Raster advance over interior centres, wrapping to (1,1) after the last.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (r_col == COL_LAST) begin
      w_col_nxt = COL_FIRST;
      if (r_row == ROW_LAST) begin
        w_row_nxt = ROW_FIRST;
      end else begin
        w_row_nxt = r_row + RW'(1);
      end
    end else begin
      w_col_nxt = r_col + CW'(1);
    end
  end

  // Centre counters and registered window; reset wins over scanning.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_row <= ROW_FIRST;
      r_col <= COL_FIRST;
      r_win <= '0;
    end else begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
      r_win <= u_bus.nb;
    end
  end

  assign out1 = r_win[0];
  assign out2 = r_win[1];
  assign out3 = r_win[2];
  assign out4 = r_win[3];
  assign out5 = r_win[4];
  assign out6 = r_win[5];
  assign out7 = r_win[6];
  assign out8 = r_win[7];

endmodule

// File: tb/tb_top_module_imp.sv
// Self-checking bench for top_module_imp with the default 16x16 image and
// built-in pattern. Directed windows are checked against hand-computed
// constants; each edge of the first frame is also checked against a small
// row/column model of the pattern.
module tb_top_module_imp;
  import top_module_imp_pkg::*;

  logic   CLK;
  logic   RST;
  pixel_t out1, out2, out3, out4, out5, out6, out7, out8;

  int n_tests;
  int n_fail;

  top_module_imp u_dut (
    .CLK  (CLK),
    .RST  (RST),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3),
    .out4 (out4),
    .out5 (out5),
    .out6 (out6),
    .out7 (out7),
    .out8 (out8)
  );

  // Observation bundle: the DUT outputs gathered into the window bus shape.
  top_module_imp_if #(.AW(8)) u_mon ();
  assign u_mon.ctr_addr = 8'd0;
  assign u_mon.nb       = {out8, out7, out6, out5, out4, out3, out2, out1};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pack the eight expected neighbours, out1 in the low byte.
  function automatic logic [63:0] pk(input int a1, input int a2, input int a3,
                                     input int a4, input int a5, input int a6,
                                     input int a7, input int a8);
    return {a8[7:0], a7[7:0], a6[7:0], a5[7:0],
            a4[7:0], a3[7:0], a2[7:0], a1[7:0]};
  endfunction

  // Expected window for the idx-th centre of a frame (16x16 image).
  function automatic logic [63:0] model_win(input int idx);
    int rr, cc;
    rr = 1 + idx / 14;
    cc = 1 + idx % 14;
    return pk((rr - 1) * 16 + cc - 1, (rr - 1) * 16 + cc, (rr - 1) * 16 + cc + 1,
              rr * 16 + cc - 1,                            rr * 16 + cc + 1,
              (rr + 1) * 16 + cc - 1, (rr + 1) * 16 + cc, (rr + 1) * 16 + cc + 1);
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RST     = 1'b1;

    step();
    check_eq("reset_edge1", u_mon.nb, 64'd0);
    step();
    check_eq("reset_edge2", u_mon.nb, 64'd0);
    RST = 1'b0;

    // First frame: 196 edges, centres (1,1) .. (14,14).
    for (int e = 1; e <= 196; e++) begin
      step();
      check_eq("frame_model", u_mon.nb, model_win(e - 1));
      if (e == 1)   check_eq("c_1_1",   u_mon.nb, pk(0, 1, 2, 16, 18, 32, 33, 34));
      if (e == 2)   check_eq("c_1_2",   u_mon.nb, pk(1, 2, 3, 17, 19, 33, 34, 35));
      if (e == 14)  check_eq("c_1_14",  u_mon.nb, pk(13, 14, 15, 29, 31, 45, 46, 47));
      if (e == 15)  check_eq("c_2_1",   u_mon.nb, pk(16, 17, 18, 32, 34, 48, 49, 50));
      if (e == 50)  check_eq("c_4_8",   u_mon.nb, pk(55, 56, 57, 71, 73, 87, 88, 89));
      if (e == 196) check_eq("c_14_14", u_mon.nb, pk(221, 222, 223, 237, 239, 253, 254, 255));
    end

    // Frame wrap.
    step();
    check_eq("wrap_1_1", u_mon.nb, pk(0, 1, 2, 16, 18, 32, 33, 34));
    step();
    check_eq("wrap_1_2", u_mon.nb, pk(1, 2, 3, 17, 19, 33, 34, 35));

    // Advance to edge 49 of the second frame, then reset on edge 50.
    for (int e = 3; e <= 49; e++) begin
      step();
    end
    check_eq("f2_c_4_7", u_mon.nb, pk(54, 55, 56, 70, 72, 86, 87, 88));
    RST = 1'b1;
    step();
    check_eq("midscan_reset", u_mon.nb, 64'd0);
    RST = 1'b0;
    step();
    check_eq("restart_1_1", u_mon.nb, pk(0, 1, 2, 16, 18, 32, 33, 34));
    step();
    check_eq("restart_1_2", u_mon.nb, pk(1, 2, 3, 17, 19, 33, 34, 35));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
